hazard_scoreboard: RTL

//  Parametrised issue-stage hazard unit for the pipelined MIPS core, replacing the fixed

---
 rtl/hazard_scoreboard_pkg.sv | 22 ++
 rtl/hazard_scoreboard_wb_slot_queue.sv | 65 ++++++
 rtl/hazard_scoreboard.sv | 85 ++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and helpers for the issue-stage hazard scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_scoreboard_pkg;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         MAX_LAT_DEF = 8;
  localparam int         LAT_W_DEF   = 4;

  // Issue latency codes presented by the controller on issue_lat.
  localparam logic [3:0] LAT_ALU     = 4'd1;
  localparam logic [3:0] LAT_LOAD    = 4'd2;
  localparam logic [3:0] LAT_MULDIV  = 4'd6;

  // A zero latency is treated as one cycle; anything beyond the deepest unit is clamped.
  function automatic int unsigned eff_latency(input int unsigned lat, input int unsigned max_lat);
    if (lat == 0) return 1;
    if (lat > max_lat) return max_lat;
    return lat;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_wb_slot_queue.sv
// Writeback reservation queue: one entry per future retire cycle, shifted every clock.
// Latency: reservation made in cycle t retires (wb_valid) in cycle t+lat.
// Backpressure: none; caller must check busy before reserving the slot at lat.
module wb_slot_queue
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_LAT = MAX_LAT_DEF,
  parameter int REG_W   = 5,
  parameter int LAT_W   = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             rsv_en,
  input  logic [LAT_W-1:0] lat,
  input  logic [REG_W-1:0] rsv_dst,
  output logic             busy,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_dst
);

  // slot_vld[j] set in cycle t means a write retires in cycle t+1+j.
  logic             slot_vld [MAX_LAT];
  logic [REG_W-1:0] slot_dst [MAX_LAT];

  // Occupancy of the slot that would retire lat cycles from now.
  always_comb begin
    busy = 1'b0;
    for (int j = 0; j < MAX_LAT; j++) begin
      if (lat == LAT_W'(j + 1)) busy = slot_vld[j];
    end
  end

  // Shift the queue toward retirement and drop a new reservation into its slot.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wb_valid <= 1'b0;
      wb_dst   <= '0;
      for (int j = 0; j < MAX_LAT; j++) begin
        slot_vld[j] <= 1'b0;
        slot_dst[j] <= '0;
      end
    end else begin
      if (rsv_en && lat == LAT_W'(1)) begin
        wb_valid <= 1'b1;
        wb_dst   <= rsv_dst;
      end else begin
        wb_valid <= slot_vld[0];
        wb_dst   <= slot_dst[0];
      end
      for (int j = 0; j < MAX_LAT - 1; j++) begin
        if (rsv_en && lat == LAT_W'(j + 2)) begin
          slot_vld[j] <= 1'b1;
          slot_dst[j] <= rsv_dst;
        end else begin
          slot_vld[j] <= slot_vld[j + 1];
          slot_dst[j] <= slot_dst[j + 1];
        end
      end
      slot_vld[MAX_LAT - 1] <= 1'b0;
      slot_dst[MAX_LAT - 1] <= '0;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard unit: per-register pending-write counters plus writeback-port reservations.
// Latency: stall is combinational in the issue cycle; wb_valid/pending update on the next edge.
// Backpressure: stall=1 holds ID on RAW, WAW or write-port conflict, and throughout reset.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int MAX_LAT  = MAX_LAT_DEF,
  parameter int LAT_W    = LAT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                issue_valid,
  input  logic [REG_W-1:0]    issue_rs,
  input  logic [REG_W-1:0]    issue_rt,
  input  logic                issue_rs_used,
  input  logic                issue_rt_used,
  input  logic                issue_wr,
  input  logic [REG_W-1:0]    issue_dst,
  input  logic [LAT_W-1:0]    issue_lat,
  output logic                stall,
  output logic                wb_valid,
  output logic [REG_W-1:0]    wb_dst,
  output logic [NUM_REGS-1:0] pending
);

  localparam logic [REG_W-1:0] ZERO = REG_W'(REG_ZERO);

  // cnt[r] = cycles until r's result is forwardable; it is 0 in the retire cycle.
  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic [LAT_W-1:0] eff_l;
  logic             raw, waw, port_conf, wr_track, slot_busy, reserve;

  // Effective latency, hazard terms and the stall decision.
  always_comb begin
    eff_l     = LAT_W'(eff_latency(32'(issue_lat), MAX_LAT));
    wr_track  = issue_wr && (issue_dst != ZERO);
    raw       = (issue_rs_used && (issue_rs != ZERO) && (cnt[issue_rs] != '0)) ||
                (issue_rt_used && (issue_rt != ZERO) && (cnt[issue_rt] != '0));
    waw       = wr_track && (cnt[issue_dst] > eff_l);
    port_conf = wr_track && slot_busy;
    stall     = 1'b1;
    if (rst) stall = issue_valid && (raw || waw || port_conf);
    // A flush squashes the issue even when it would otherwise be accepted.
    reserve   = issue_valid && !stall && !flush && wr_track;
  end

  // Counters tick down each cycle; a new write loads L-1 because one cycle elapses across the issue edge.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (reserve && issue_dst == REG_W'(r)) cnt[r] <= eff_l - LAT_W'(1);
        else if (cnt[r] != '0)                  cnt[r] <= cnt[r] - LAT_W'(1);
      end
    end
  end

  // Pending flags mirror the counter flops; register 0 is never tracked.
  always_comb begin
    pending = '0;
    for (int r = 1; r < NUM_REGS; r++) pending[r] = (cnt[r] != '0);
  end

  wb_slot_queue #(
    .MAX_LAT (MAX_LAT),
    .REG_W   (REG_W),
    .LAT_W   (LAT_W)
  ) u_slots (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .rsv_en   (reserve),
    .lat      (eff_l),
    .rsv_dst  (issue_dst),
    .busy     (slot_busy),
    .wb_valid (wb_valid),
    .wb_dst   (wb_dst)
  );

endmodule
